// File: rtl/seg7_pkg.sv
// Shared constants and types for the 3-digit multiplexed 7-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {StDig0, StDig1, StDig2} slot_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; codes 10..15 blank the digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// 3-digit multiplexed 7-segment scanner with frame-atomic digit updates.
// Define LEAD_ZERO_BLANK_EN to blank leading zeros on digits 2 and 1.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dec_in0,
  input  logic [3:0] dec_in1,
  input  logic [3:0] dec_in2,
  input  logic       in_vld,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       frame_done
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] div_q;
  logic            tick;
  slot_e           slot_q, slot_d;

  logic [NUM_DIGITS-1:0][3:0] in_digits, pending_q, display_q, display_d, shown;
  logic [3:0] dig_sel;
  logic [2:0] an_d;
  logic [6:0] seg_dec;
  logic [6:0] seg_n_q;
  logic [2:0] an_n_q;
  logic       frame_done_q;

  assign tick      = (div_q == DivLast);
  assign in_digits = {dec_in2, dec_in1, dec_in0};

  always_comb begin
    slot_d    = slot_q;
    display_d = display_q;
    dig_sel   = 4'hF;
    an_d      = 3'b111;

    // Display only reloads at the start of a frame; a strobe on that very tick wins.
    if (tick && (slot_q == StDig0)) begin
      display_d = in_vld ? in_digits : pending_q;
    end

    shown = display_d;
`ifdef LEAD_ZERO_BLANK_EN
    if (display_d[2] == 4'd0) begin
      shown[2] = 4'hF;
    end
    if ((display_d[2] == 4'd0) && (display_d[1] == 4'd0)) begin
      shown[1] = 4'hF;
    end
`endif

    case (slot_q)
      StDig0: begin
        dig_sel = shown[0];
        an_d    = 3'b110;
        if (tick) slot_d = StDig1;
      end
      StDig1: begin
        dig_sel = shown[1];
        an_d    = 3'b101;
        if (tick) slot_d = StDig2;
      end
      StDig2: begin
        dig_sel = shown[2];
        an_d    = 3'b011;
        if (tick) slot_d = StDig0;
      end
      default: begin
        slot_d = StDig0;
      end
    endcase
  end

  seg7_decode u_decode (
    .bcd   (dig_sel),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      slot_q       <= StDig0;
      pending_q    <= '0;
      display_q    <= '0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= 3'b111;
      frame_done_q <= 1'b0;
    end else begin
      div_q  <= tick ? '0 : div_q + DivW'(1);
      slot_q <= slot_d;
      if (in_vld) begin
        pending_q <= in_digits;
      end
      display_q <= display_d;
      if (tick) begin
        seg_n_q <= seg_dec;
        an_n_q  <= an_d;
      end
      frame_done_q <= tick && (slot_q == StDig2);
    end
  end

  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at SCAN_DIV=4; honours LEAD_ZERO_BLANK_EN.
module tb_seg7_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dec_in0 = '0;
  logic [3:0] dec_in1 = '0;
  logic [3:0] dec_in2 = '0;
  logic       in_vld = 1'b0;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic       frame_done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_slot = 0;

  // Expected slot result: {frame_done, an_n, seg_n}
  logic [10:0] exp_q[$];

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_in0    (dec_in0),
    .dec_in1    (dec_in1),
    .dec_in2    (dec_in2),
    .in_vld     (in_vld),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge, so slot updates land where cyc % 4 == 0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push_frame(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    logic [6:0] s1, s2;
    s1 = exp_seg(d1);
    s2 = exp_seg(d2);
`ifdef LEAD_ZERO_BLANK_EN
    if (d2 == 4'd0) s2 = 7'b1111111;
    if (d2 == 4'd0 && d1 == 4'd0) s1 = 7'b1111111;
`endif
    exp_q.push_back({1'b0, 3'b110, exp_seg(d0)});
    exp_q.push_back({1'b0, 3'b101, s1});
    exp_q.push_back({1'b1, 3'b011, s2});
  endtask

  // Advance to the next slot update; any strobe raised before the call lasts one cycle.
  task automatic wait_slot(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_vld = 1'b0;
      if (cyc != 0 && (cyc % 4) == 0 && cyc != last_slot) begin
        last_slot = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst = 1'b1;
    in_vld = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_slot = 0;
  endtask

  task automatic test_reset;
    bit ok;
    logic [10:0] exp;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seg_n !== 7'b1111111) begin
      n_err++; $display("FAIL reset_seg: got %b want 1111111", seg_n);
    end
    n_checks++;
    if (an_n !== 3'b111) begin
      n_err++; $display("FAIL reset_an: got %b want 111", an_n);
    end
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL reset_fd: got %b want 0", frame_done);
    end
    rst = 1'b0;
    last_slot = 0;
    exp_q.delete();
    push_frame(4'd0, 4'd0, 4'd0);
    for (int s = 0; s < 3; s++) begin
      wait_slot(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {frame_done, an_n, seg_n} !== exp) begin
        n_err++;
        $display("FAIL reset_scan slot %0d: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
                 s, frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
      end
    end
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_err++; $display("FAIL fd_pulse_width: got %b want 0", frame_done);
    end
  endtask

  task automatic test_mid_frame_update;
    bit ok;
    logic [10:0] exp;
    release_reset();
    push_frame(4'd0, 4'd0, 4'd0);
    push_frame(4'd2, 4'd5, 4'd7);
    for (int s = 0; s < 6; s++) begin
      wait_slot(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {frame_done, an_n, seg_n} !== exp) begin
        n_err++;
        $display("FAIL mid_frame slot %0d: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
                 s, frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
      end
      if (s == 0) begin
        {dec_in2, dec_in1, dec_in0} = {4'd2, 4'd5, 4'd7};
        in_vld = 1'b1;
      end
    end
  endtask

  task automatic test_blank_digit;
    bit ok;
    logic [10:0] exp;
    release_reset();
    {dec_in2, dec_in1, dec_in0} = {4'd1, 4'd3, 4'd12};
    in_vld = 1'b1;
    push_frame(4'd1, 4'd3, 4'd12);
    for (int s = 0; s < 3; s++) begin
      wait_slot(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {frame_done, an_n, seg_n} !== exp) begin
        n_err++;
        $display("FAIL blank_digit slot %0d: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
                 s, frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
      end
    end
  endtask

  task automatic test_coincident_tick;
    bit ok;
    logic [10:0] exp;
    release_reset();
    push_frame(4'd0, 4'd0, 4'd0);
    push_frame(4'd0, 4'd0, 4'd7);
    for (int s = 0; s < 6; s++) begin
      // Strobe lands in the tick cycle of the second frame's digit-0 slot.
      if (s == 3) begin
        for (int i = 0; i < 8 && cyc != 15; i++) @(negedge clk);
        {dec_in2, dec_in1, dec_in0} = {4'd0, 4'd0, 4'd7};
        in_vld = 1'b1;
      end
      wait_slot(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {frame_done, an_n, seg_n} !== exp) begin
        n_err++;
        $display("FAIL coincident slot %0d: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
                 s, frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    bit fd_seen;
    logic [10:0] exp;
    release_reset();
    push_frame(4'd0, 4'd0, 4'd0);
    for (int s = 0; s < 2; s++) begin
      wait_slot(ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || {frame_done, an_n, seg_n} !== exp) begin
        n_err++;
        $display("FAIL pre_abort slot %0d: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
                 s, frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_slot = 0;
    n_checks++;
    if ({frame_done, an_n, seg_n} !== {1'b0, 3'b111, 7'b1111111}) begin
      n_err++;
      $display("FAIL abort_outputs: got fd=%b an=%b seg=%b want fd=0 an=111 seg=1111111",
               frame_done, an_n, seg_n);
    end
    fd_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fd_seen = 1'b1;
    end
    n_checks++;
    if (fd_seen) begin
      n_err++; $display("FAIL abort_no_fd: got frame_done pulse want none");
    end
    push_frame(4'd0, 4'd0, 4'd0);
    wait_slot(ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || {frame_done, an_n, seg_n} !== exp) begin
      n_err++;
      $display("FAIL restart_slot: got fd=%b an=%b seg=%b want fd=%b an=%b seg=%b ok=%0d",
               frame_done, an_n, seg_n, exp[10], exp[9:7], exp[6:0], ok);
    end
  endtask

  initial begin
    test_reset();
    test_mid_frame_update();
    test_blank_digit();
    test_coincident_tick();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
